nios_accelerometer_key_in: RTL and testbench



---
 rtl/nios_accelerometer_key_in_if.sv | 31 +++
 rtl/nios_accelerometer_key_in.sv | 165 ++++++++++++++++
 tb/tb_nios_accelerometer_key_in.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/nios_accelerometer_key_in_if.sv
// Avalon-MM slave bus bundle for the key/switch input PIO.
// Handshake: zero-wait-state Avalon-MM. A write is taken on the clock edge
// where chipselect is high and write_n is low. readdata is combinational
// from address and is valid in the same cycle with no side effects.
// irq is a registered, active-high level interrupt.
interface nios_accelerometer_key_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata,
        input  irq
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata,
        output irq
    );
endinterface

// File: rtl/nios_accelerometer_key_in.sv
// Avalon-MM input PIO for push-buttons and switches.
// Pads are brought into the clk domain by a two-flop synchroniser, optionally
// debounced, then edge-detected into a sticky RW1C edge-capture register that
// drives a maskable level interrupt.
// Optional debounce filter: define KEY_DEBOUNCE_EN.
// Register map (word addresses):
//   0 data        RO   {0, level}
//   1 reserved    reads 0, writes ignored
//   2 irqmask     RW   [WIDTH-1:0]
//   3 edgecapture RW1C [WIDTH-1:0]
module nios_accelerometer_key_in #(
    parameter int               WIDTH           = 4,
    parameter int               EDGE_TYPE       = 1,
    parameter logic [WIDTH-1:0] IN_RESET_VAL    = {WIDTH{1'b1}},
    parameter int               DEBOUNCE_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH-1:0]     in_port,
    nios_accelerometer_key_in_if.slave bus
);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_RSVD = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] edge_comb;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic [WIDTH-1:0] w1c_mask;
    logic             wr_en;
    logic             irq_q;
    logic [31:0]      rd_data;
    logic             unused_bits;

    assign wr_en = bus.chipselect & ~bus.write_n;

    // Two-flop synchroniser; reset to the idle pad level so release is quiet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= IN_RESET_VAL;
            sync2 <= IN_RESET_VAL;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int              CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0]    db_cnt [WIDTH];
    logic [WIDTH-1:0] db_level;

    // Per-bit stability counter: a new level is accepted only after it has
    // differed from the debounced level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_level <= IN_RESET_VAL;
            for (int i = 0; i < WIDTH; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == CNT_LAST) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign level = db_level;
`else
    assign level = sync2;
`endif

    // Select which transition of the filtered level counts as an edge.
    always_comb begin
        edge_comb = '0;
        case (EDGE_TYPE)
            0:       edge_comb = level & ~prev;
            1:       edge_comb = ~level & prev;
            default: edge_comb = level ^ prev;
        endcase
    end

    // History flop and registered one-cycle edge pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev   <= IN_RESET_VAL;
            edge_q <= '0;
        end else begin
            prev   <= level;
            edge_q <= edge_comb;
        end
    end

    // Bits the current write asks to clear in the edge-capture register.
    always_comb begin
        w1c_mask = '0;
        if (wr_en && (bus.address == ADDR_EDGE)) begin
            w1c_mask = bus.writedata[WIDTH-1:0];
        end
    end

    // Interrupt mask register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (wr_en && (bus.address == ADDR_MASK)) begin
            irqmask <= bus.writedata[WIDTH-1:0];
        end
    end

    // Sticky edge capture; the set term is OR-ed last so an edge arriving in
    // the same cycle as its clear is never lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecapture <= '0;
        end else begin
            edgecapture <= (edgecapture & ~w1c_mask) | edge_q;
        end
    end

    // Registered level interrupt from any unmasked captured edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(edgecapture & irqmask);
        end
    end

    // Zero-wait-state read mux; unused upper bits read as zero.
    always_comb begin
        rd_data = '0;
        case (bus.address)
            ADDR_DATA: rd_data[WIDTH-1:0] = level;
            ADDR_RSVD: rd_data = '0;
            ADDR_MASK: rd_data[WIDTH-1:0] = irqmask;
            ADDR_EDGE: rd_data[WIDTH-1:0] = edgecapture;
            default:   rd_data = '0;
        endcase
    end

    assign bus.readdata = rd_data;
    assign bus.irq      = irq_q;

    // Upper write-data bits and the debounce length have no effect in every
    // build; fold them into a sink so they are visibly intentional.
    assign unused_bits = ^{bus.writedata, 32'(DEBOUNCE_CYCLES)};

endmodule

// File: tb/tb_nios_accelerometer_key_in.sv
// Directed bench for nios_accelerometer_key_in (WIDTH=4, falling-edge capture).
// With KEY_DEBOUNCE_EN defined the timing section exercises the debounce
// filter (DEBOUNCE_CYCLES=8) instead of the unfiltered latency checks.
module tb_nios_accelerometer_key_in;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] in_port;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

`ifdef KEY_DEBOUNCE_EN
    localparam int SETTLE = 14;
`else
    localparam int SETTLE = 5;
`endif

    nios_accelerometer_key_in_if bus ();

    nios_accelerometer_key_in #(
        .WIDTH           (4),
        .EDGE_TYPE       (1),
        .IN_RESET_VAL    (4'hF),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .in_port (in_port),
        .bus     (bus)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One full cycle, ending on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed=%h", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_reg(input logic [1:0] a, input logic [31:0] e, input string tag);
        bus.address = a;
        #1;
        exp_q.push_back(e);
        check(tag, bus.readdata);
    endtask

    task automatic expect_irq(input logic e, input string tag);
        exp_q.push_back({31'b0, e});
        check(tag, {31'b0, bus.irq});
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        tick();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    initial begin
        logic [3:0] cur;
        logic [3:0] nxt;
        logic [3:0] fall;

        // Reset
        reset_n        = 1'b0;
        in_port        = 4'hF;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        repeat (3) tick();
        expect_irq(1'b0, "irq_in_reset");
        expect_reg(2'd3, 32'h0, "edge_in_reset");
        reset_n = 1'b1;
        tick();

        // Register map after reset
        expect_reg(2'd0, 32'h0000_000F, "data_reset");
        expect_reg(2'd3, 32'h0, "edge_reset");
        expect_reg(2'd2, 32'h0, "mask_reset");
        expect_irq(1'b0, "irq_reset");
        bus_write(2'd1, 32'hFFFF_FFFF);
        expect_reg(2'd1, 32'h0, "rsvd_read");
        bus_write(2'd0, 32'h0000_0000);
        expect_reg(2'd0, 32'h0000_000F, "data_ro");
        repeat (4) tick();
        expect_reg(2'd3, 32'h0, "no_spurious_edge");
        bus_write(2'd2, 32'hFFFF_FFF2);
        expect_reg(2'd2, 32'h0000_0002, "mask_upper_zero");

`ifdef KEY_DEBOUNCE_EN
        // 5-cycle glitch on bit 1 is filtered out
        in_port = 4'hD;
        repeat (5) tick();
        in_port = 4'hF;
        repeat (20) tick();
        expect_reg(2'd0, 32'hF, "db_glitch_data");
        expect_reg(2'd3, 32'h0, "db_glitch_edge");

        // 12-cycle low on bit 1 is accepted after the filter window
        in_port = 4'hD;
        repeat (9) tick();
        expect_reg(2'd0, 32'hF, "db_data_before");
        tick();
        expect_reg(2'd0, 32'hD, "db_data_after");
        tick();
        tick();
        in_port = 4'hF;
        repeat (20) tick();
        expect_reg(2'd3, 32'h2, "db_edge_captured");
        expect_irq(1'b1, "db_irq");
        expect_reg(2'd0, 32'hF, "db_data_restored");

        // Reset in the middle of a count
        in_port = 4'h7;
        repeat (4) tick();
        reset_n = 1'b0;
        #1;
        expect_irq(1'b0, "db_irq_async_reset");
        expect_reg(2'd3, 32'h0, "db_edge_reset");
        expect_reg(2'd2, 32'h0, "db_mask_reset");
        expect_reg(2'd0, 32'hF, "db_data_reset");
        in_port = 4'hF;
        tick();
        reset_n = 1'b1;
        repeat (20) tick();
        expect_reg(2'd3, 32'h0, "db_post_reset_quiet");
`else
        // Falling edge on bit 1: captured after edge N+3, irq one cycle later
        in_port = 4'hD;
        tick();
        tick();
        expect_reg(2'd0, 32'hD, "data_sync");
        tick();
        expect_reg(2'd3, 32'h0, "edge_not_yet");
        tick();
        expect_reg(2'd3, 32'h2, "edge_latency");
        expect_irq(1'b0, "irq_not_yet");
        tick();
        expect_irq(1'b1, "irq_set");
        in_port = 4'hF;
        repeat (6) tick();
        expect_reg(2'd3, 32'h2, "rising_ignored");
        expect_irq(1'b1, "irq_held");

        // W1C behaviour
        bus_write(2'd3, 32'h0);
        expect_reg(2'd3, 32'h2, "w0_no_effect");
        bus_write(2'd3, 32'h2);
        expect_reg(2'd3, 32'h0, "w1c_clear");
        expect_irq(1'b1, "irq_lag");
        tick();
        expect_irq(1'b0, "irq_drop");

        // Edge pulse lands on the same edge as a W1C of that bit
        in_port = 4'hE;
        repeat (3) tick();
        expect_reg(2'd3, 32'h0, "collide_pre");
        bus_write(2'd3, 32'h1);
        expect_reg(2'd3, 32'h1, "collide_set_wins");
        in_port = 4'hF;
        repeat (5) tick();
        bus_write(2'd3, 32'h1);
        expect_reg(2'd3, 32'h0, "collide_cleanup");

        // Capture with mask off, then unmask
        bus_write(2'd2, 32'h0);
        tick();
        in_port = 4'h7;
        repeat (4) tick();
        expect_reg(2'd3, 32'h8, "masked_capture");
        tick();
        expect_irq(1'b0, "masked_irq_low");
        bus_write(2'd2, 32'h8);
        expect_irq(1'b0, "unmask_lag");
        expect_reg(2'd3, 32'h8, "mask_keeps_edge");
        tick();
        expect_irq(1'b1, "unmask_irq");

        // Asynchronous reset mid-operation
        reset_n = 1'b0;
        #1;
        expect_irq(1'b0, "irq_async_reset");
        expect_reg(2'd3, 32'h0, "edge_async_reset");
        expect_reg(2'd2, 32'h0, "mask_async_reset");
        in_port = 4'hF;
        tick();
        reset_n = 1'b1;
        repeat (6) tick();
        expect_reg(2'd3, 32'h0, "post_reset_quiet");
`endif

        // Random pad patterns against a falling-edge model
        bus_write(2'd2, 32'hF);
        cur = 4'hF;
        for (int k = 0; k < 8; k++) begin
            nxt = 4'($urandom_range(0, 15));
            fall = cur & ~nxt;
            in_port = nxt;
            repeat (SETTLE) tick();
            expect_reg(2'd0, {28'b0, nxt}, "rand_data");
            expect_reg(2'd3, {28'b0, fall}, "rand_edge");
            expect_irq(|fall, "rand_irq");
            bus_write(2'd3, 32'hF);
            tick();
            expect_reg(2'd3, 32'h0, "rand_clear");
            expect_irq(1'b0, "rand_irq_clear");
            cur = nxt;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
